// File: rtl/ct_ifu_ind_btb_access_if.sv
// ct_ifu_ind_btb_access_if: lookup/update request bus of the indirect BTB
//   master: drives rd_vld/rd_index and wr_vld/wr_index/wr_data;
//           receives rd_rdy, wr_rdy, rd_data_vld, rd_data
//   slave : the BTB access block
interface ct_ifu_ind_btb_access_if;
   logic        rd_vld;
   logic [7:0]  rd_index;
   logic        rd_rdy;
   logic        wr_vld;
   logic [7:0]  wr_index;
   logic [22:0] wr_data;
   logic        wr_rdy;
   logic        rd_data_vld;
   logic [22:0] rd_data;
   modport master (
      output rd_vld, rd_index, wr_vld, wr_index, wr_data,
      input  rd_rdy, wr_rdy, rd_data_vld, rd_data
   );
   modport slave (
      input  rd_vld, rd_index, wr_vld, wr_index, wr_data,
      output rd_rdy, wr_rdy, rd_data_vld, rd_data
   );
endinterface

// File: rtl/ct_ifu_ind_btb_access.sv
// ct_ifu_ind_btb_access: indirect BTB array sequencer (invalidate walk, update, lookup)
//   forever_cpuclk/cpurst       : clock, synchronous active-high reset
//   cp0_ifu_ind_btb_en/_inv     : enable for lookups/updates, invalidate-all request
//   acc                         : lookup/update request bus (slave side)
//   inv_busy                    : invalidation walk in progress
//   ind_btb_*                   : single-port array control, write data and read data
module ct_ifu_ind_btb_access (
   input  logic                    forever_cpuclk,
   input  logic                    cpurst,
   input  logic                    cp0_ifu_ind_btb_en,
   input  logic                    cp0_ifu_ind_btb_inv,
   ct_ifu_ind_btb_access_if.slave  acc,
   output logic                    inv_busy,
   output logic                    ind_btb_cen_b,
   output logic                    ind_btb_wen_b,
   output logic                    ind_btb_clk_en,
   output logic [7:0]              ind_btb_index,
   output logic [22:0]             ind_btb_data_in,
   input  logic [22:0]             ind_btb_dout
);
   typedef enum logic {INV, IDLE} state_t;
   state_t      state, state_nxt;
   logic [7:0]  inv_cnt, inv_cnt_nxt;
   logic        inv_wr, wr_fire, rd_fire, rd_vld_q;
   logic [22:0] rd_hold;
   always_ff @(posedge forever_cpuclk)
      if (cpurst) begin
         state   <= INV;
         inv_cnt <= '0;
      end else begin
         state   <= state_nxt;
         inv_cnt <= inv_cnt_nxt;
      end
   // The counter wraps 255->0 on the last walk write, which is also where the walk ends.
   always_comb begin
      state_nxt   = cp0_ifu_ind_btb_inv ? INV :
                    (state == INV && inv_cnt != 8'hff) ? INV : IDLE;
      inv_cnt_nxt = (state == INV && !cp0_ifu_ind_btb_inv) ? inv_cnt + 8'd1 : 8'd0;
   end
   // Updates win over lookups; nothing is accepted in the cycle an invalidate is taken.
   always_comb begin
      inv_wr          = !cpurst && state == INV;
      inv_busy        = cpurst || state == INV;
      acc.wr_rdy      = !cpurst && state == IDLE && cp0_ifu_ind_btb_en && !cp0_ifu_ind_btb_inv;
      acc.rd_rdy      = acc.wr_rdy && !acc.wr_vld;
      wr_fire         = acc.wr_vld && acc.wr_rdy;
      rd_fire         = acc.rd_vld && acc.rd_rdy;
      ind_btb_cen_b   = !(inv_wr || wr_fire || rd_fire);
      ind_btb_wen_b   = !(inv_wr || wr_fire);
      ind_btb_clk_en  = !ind_btb_cen_b;
      ind_btb_index   = inv_wr ? inv_cnt : wr_fire ? acc.wr_index : rd_fire ? acc.rd_index : 8'd0;
      ind_btb_data_in = wr_fire ? acc.wr_data : 23'd0;
      acc.rd_data_vld = rd_vld_q && !cpurst;
      acc.rd_data     = cpurst ? 23'd0 : rd_vld_q ? ind_btb_dout : rd_hold;
   end
   // Array Q is only valid in the cycle after a read, so it is captured for later cycles.
   always_ff @(posedge forever_cpuclk)
      if (cpurst) begin
         rd_vld_q <= 1'b0;
         rd_hold  <= '0;
      end else begin
         rd_vld_q <= rd_fire;
         if (rd_vld_q) rd_hold <= ind_btb_dout;
      end
endmodule

// File: tb/tb_ct_ifu_ind_btb_access.sv
// tb_ct_ifu_ind_btb_access: directed table, corner sequences and random traffic against a reference model
module tb_ct_ifu_ind_btb_access;
   logic        clk = 1'b0;
   logic        rst, en, inv;
   logic        cen_b, wen_b, clk_en, busy;
   logic [7:0]  idx;
   logic [22:0] din, dout;
   logic [22:0] sram [256];
   int          n_cmp = 0, n_bad = 0;
   ct_ifu_ind_btb_access_if bus ();
   ct_ifu_ind_btb_access dut (
      .forever_cpuclk(clk), .cpurst(rst), .cp0_ifu_ind_btb_en(en), .cp0_ifu_ind_btb_inv(inv),
      .acc(bus.slave), .inv_busy(busy), .ind_btb_cen_b(cen_b), .ind_btb_wen_b(wen_b),
      .ind_btb_clk_en(clk_en), .ind_btb_index(idx), .ind_btb_data_in(din), .ind_btb_dout(dout)
   );
   always #5 clk = ~clk;
   always @(posedge clk)
      if (!cen_b) begin
         if (!wen_b) sram[idx] <= din;
         else dout <= sram[idx];
      end
   // reference model: walk position, expected array contents, pending lookup result
   bit          m_busy, m_pvld, x_wr, x_rd;
   int          m_pos, x_idx;
   logic [22:0] m_pdata, m_hold, x_d;
   logic [22:0] m_mem [256];
   typedef struct {
      bit en, inv, rv; logic [7:0] ri; bit wv; logic [7:0] wi; logic [22:0] wd;
      bit cen, wen, rrdy, wrdy, dv; logic [22:0] rd;
   } vec_t;
   vec_t tbl [11];
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask
   task automatic drive(input bit r, input bit e, input bit i, input bit rv, input logic [7:0] ri,
                        input bit wv, input logic [7:0] wi, input logic [22:0] wd);
      rst = r; en = e; inv = i;
      bus.rd_vld = rv; bus.rd_index = ri; bus.wr_vld = wv; bus.wr_index = wi; bus.wr_data = wd;
   endtask
   task automatic check_model();
      bit ecen, ewen, err, ewr;
      ecen = 1; ewen = 1; err = 0; ewr = 0; x_wr = 0; x_rd = 0; x_idx = 0; x_d = '0;
      if (!rst) begin
         if (m_busy) begin
            x_wr = 1; x_idx = m_pos;
         end else if (!inv && en) begin
            ewr = 1; err = !bus.wr_vld;
            if (bus.wr_vld) begin
               x_wr = 1; x_idx = int'(bus.wr_index); x_d = bus.wr_data;
            end else if (bus.rd_vld) begin
               x_rd = 1; x_idx = int'(bus.rd_index);
            end
         end
      end
      ecen = !(x_wr || x_rd);
      ewen = !x_wr;
      chk("cen_b", 32'(cen_b), 32'(ecen));
      chk("wen_b", 32'(wen_b), 32'(ewen));
      chk("clk_en", 32'(clk_en), 32'(!ecen));
      chk("index", 32'(idx), 32'(x_idx));
      chk("data_in", 32'(din), 32'(x_d));
      chk("rd_rdy", 32'(bus.rd_rdy), 32'(err));
      chk("wr_rdy", 32'(bus.wr_rdy), 32'(ewr));
      chk("inv_busy", 32'(busy), 32'(rst || m_busy));
      chk("rd_data_vld", 32'(bus.rd_data_vld), 32'(!rst && m_pvld));
      chk("rd_data", 32'(bus.rd_data), rst ? 32'd0 : m_pvld ? 32'(m_pdata) : 32'(m_hold));
   endtask
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_busy = 1; m_pos = 0; m_pvld = 0; m_hold = '0;
      end else begin
         if (m_pvld) m_hold = m_pdata;
         m_pvld = x_rd;
         if (x_rd) m_pdata = m_mem[x_idx];
         if (x_wr) m_mem[x_idx] = x_d;
         if (m_busy) begin
            if (inv) m_pos = 0;
            else if (m_pos == 255) begin m_busy = 0; m_pos = 0; end
            else m_pos++;
         end else if (inv) begin
            m_busy = 1; m_pos = 0;
         end
      end
      @(negedge clk);
   endtask
   task automatic apply(input bit r, input bit e, input bit i, input bit rv, input logic [7:0] ri,
                        input bit wv, input logic [7:0] wi, input logic [22:0] wd);
      drive(r, e, i, rv, ri, wv, wi, wd);
      #1 check_model();
   endtask
   task automatic step(input bit r, input bit e, input bit i, input bit rv, input logic [7:0] ri,
                       input bit wv, input logic [7:0] wi, input logic [22:0] wd);
      apply(r, e, i, rv, ri, wv, wi, wd);
      tick();
   endtask
   initial begin
      tbl[0]  = '{1, 0, 0, 8'h00, 1, 8'h3A, 23'h12345, 0, 0, 0, 1, 0, 23'h0};
      tbl[1]  = '{1, 0, 1, 8'h3A, 0, 8'h00, 23'h0,     0, 1, 1, 1, 0, 23'h0};
      tbl[2]  = '{1, 0, 0, 8'h00, 0, 8'h00, 23'h0,     1, 1, 1, 1, 1, 23'h12345};
      tbl[3]  = '{1, 0, 0, 8'h00, 0, 8'h00, 23'h0,     1, 1, 1, 1, 0, 23'h12345};
      tbl[4]  = '{1, 0, 1, 8'h10, 1, 8'h10, 23'h55AA,  0, 0, 0, 1, 0, 23'h12345};
      tbl[5]  = '{1, 0, 1, 8'h10, 0, 8'h00, 23'h0,     0, 1, 1, 1, 0, 23'h12345};
      tbl[6]  = '{1, 0, 0, 8'h00, 0, 8'h00, 23'h0,     1, 1, 1, 1, 1, 23'h55AA};
      tbl[7]  = '{0, 0, 1, 8'h3A, 1, 8'h3A, 23'h7FFFF, 1, 1, 0, 0, 0, 23'h55AA};
      tbl[8]  = '{0, 0, 1, 8'h3A, 0, 8'h00, 23'h0,     1, 1, 0, 0, 0, 23'h55AA};
      tbl[9]  = '{1, 0, 1, 8'h3A, 0, 8'h00, 23'h0,     0, 1, 1, 1, 0, 23'h55AA};
      tbl[10] = '{1, 1, 1, 8'h10, 0, 8'h00, 23'h0,     1, 1, 0, 0, 1, 23'h12345};
      drive(1, 1, 0, 0, 8'h0, 0, 8'h0, 23'h0);
      @(negedge clk);
      repeat (3) step(1, 1, 0, 1, 8'h3A, 1, 8'h3A, 23'h1);
      // reset release: 256 zero writes in index order while requests are held off
      for (int k = 0; k < 256; k++) begin
         apply(0, 1, 0, 1, 8'(k), 1, 8'(k), 23'h7);
         chk("walk_idx", 32'(idx), 32'(k));
         chk("walk_busy", 32'(busy), 32'd1);
         tick();
      end
      apply(0, 1, 0, 0, 8'h0, 0, 8'h0, 23'h0);
      chk("walk_done", 32'(busy), 32'd0);
      tick();
      for (int i = 0; i < 11; i++) begin
         apply(0, tbl[i].en, tbl[i].inv, tbl[i].rv, tbl[i].ri, tbl[i].wv, tbl[i].wi, tbl[i].wd);
         chk("t_cen_b", 32'(cen_b), 32'(tbl[i].cen));
         chk("t_wen_b", 32'(wen_b), 32'(tbl[i].wen));
         chk("t_rd_rdy", 32'(bus.rd_rdy), 32'(tbl[i].rrdy));
         chk("t_wr_rdy", 32'(bus.wr_rdy), 32'(tbl[i].wrdy));
         chk("t_rd_data_vld", 32'(bus.rd_data_vld), 32'(tbl[i].dv));
         chk("t_rd_data", 32'(bus.rd_data), 32'(tbl[i].rd));
         tick();
      end
      // invalidate pulse at inv_cnt=100 restarts the walk at index 0
      for (int k = 0; k < 100; k++) begin
         apply(0, 1, 0, 0, 8'h0, 0, 8'h0, 23'h0);
         chk("inv_idx", 32'(idx), 32'(k));
         tick();
      end
      apply(0, 1, 1, 0, 8'h0, 0, 8'h0, 23'h0);
      chk("inv_pulse_idx", 32'(idx), 32'd100);
      tick();
      for (int k = 0; k < 256; k++) begin
         apply(0, 0, 0, 1, 8'h1, 1, 8'h2, 23'h3);
         chk("restart_idx", 32'(idx), 32'(k));
         tick();
      end
      apply(0, 1, 0, 0, 8'h0, 0, 8'h0, 23'h0);
      chk("restart_done", 32'(busy), 32'd0);
      tick();
      for (int n = 0; n < 3000; n++)
         step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 399) == 0,
              1'($urandom), 8'($urandom_range(240, 255)), 1'($urandom),
              8'($urandom_range(240, 255)), 23'($urandom));
      // reset at inv_cnt=200 restarts the walk; index 0xFF then reads back 0
      step(1, 1, 0, 0, 8'h0, 0, 8'h0, 23'h0);
      repeat (200) step(0, 1, 0, 0, 8'h0, 0, 8'h0, 23'h0);
      step(1, 1, 0, 1, 8'hFF, 0, 8'h0, 23'h0);
      for (int k = 0; k < 256; k++) begin
         apply(0, 1, 0, 0, 8'h0, 0, 8'h0, 23'h0);
         chk("rst_walk_idx", 32'(idx), 32'(k));
         tick();
      end
      step(0, 1, 0, 0, 8'h0, 1, 8'hFF, 23'h4321);
      step(0, 1, 1, 0, 8'h0, 0, 8'h0, 23'h0);
      repeat (256) step(0, 1, 0, 0, 8'h0, 0, 8'h0, 23'h0);
      step(0, 1, 0, 1, 8'hFF, 0, 8'h0, 23'h0);
      apply(0, 1, 0, 0, 8'h0, 0, 8'h0, 23'h0);
      chk("ff_vld", 32'(bus.rd_data_vld), 32'd1);
      chk("ff_data", 32'(bus.rd_data), 32'd0);
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
